// File: rtl/index_mem_dual_pkg.sv
// Shared widths and depth for the dual-channel index/data memory.
package index_mem_dual_pkg;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;
endpackage

// File: rtl/index_mem_bank.sv
// One channel: data/index storage with a write port and a registered read port.
import index_mem_dual_pkg::*;

module index_mem_bank #(
   parameter int unsigned DATA_W = index_mem_dual_pkg::DATA_W,
   parameter int unsigned IDX_W  = index_mem_dual_pkg::IDX_W,
   parameter int unsigned DEPTH  = index_mem_dual_pkg::DEPTH,
   parameter int unsigned ADDR_W = index_mem_dual_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic [IDX_W-1:0]  idx_in,
   input  logic [ADDR_W-1:0] cnt,
   output logic [DATA_W-1:0] dout,
   output logic [IDX_W-1:0]  idx_out
);

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [IDX_W-1:0]  idx_mem  [DEPTH];

   // Non-blocking read of the same array gives read-before-write on address collisions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_mem[k] <= '0;
            idx_mem[k]  <= '0;
         end
         dout    <= '0;
         idx_out <= '0;
      end else begin
         if (wr_en) begin
            data_mem[addr] <= din;
            idx_mem[addr]  <= idx_in;
         end
         dout    <= data_mem[cnt];
         idx_out <= idx_mem[cnt];
      end
   end

endmodule

// File: rtl/index_mem_dual.sv
// Dual-channel index/data memory: two independent banks sharing clock, reset and wr_en.
import index_mem_dual_pkg::*;

module index_mem_dual #(
   parameter int unsigned DATA_W = index_mem_dual_pkg::DATA_W,
   parameter int unsigned IDX_W  = index_mem_dual_pkg::IDX_W,
   parameter int unsigned DEPTH  = index_mem_dual_pkg::DEPTH,
   parameter int unsigned ADDR_W = index_mem_dual_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr1w,
   input  logic [ADDR_W-1:0] addr2w,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] din2,
   input  logic [IDX_W-1:0]  i1,
   input  logic [IDX_W-1:0]  i2,
   input  logic [ADDR_W-1:0] cnt1w,
   input  logic [ADDR_W-1:0] cnt2w,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [IDX_W-1:0]  r1,
   output logic [IDX_W-1:0]  r2
);

   index_mem_bank #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_bank1 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .addr    (addr1w),
      .din     (din1),
      .idx_in  (i1),
      .cnt     (cnt1w),
      .dout    (out1),
      .idx_out (r1)
   );

   index_mem_bank #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_bank2 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .addr    (addr2w),
      .din     (din2),
      .idx_in  (i2),
      .cnt     (cnt2w),
      .dout    (out2),
      .idx_out (r2)
   );

endmodule

// File: tb/tb_index_mem_dual.sv
// Directed self-checking bench for index_mem_dual.
module tb_index_mem_dual;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [3:0] addr1w, addr2w, cnt1w, cnt2w;
   logic [7:0] din1, din2, i1, i2;
   logic [7:0] out1, out2, r1, r2;

   int total = 0;
   int bad   = 0;

   index_mem_dual dut (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .addr1w (addr1w),
      .addr2w (addr2w),
      .din1   (din1),
      .din2   (din2),
      .i1     (i1),
      .i2     (i2),
      .cnt1w  (cnt1w),
      .cnt2w  (cnt2w),
      .out1   (out1),
      .out2   (out2),
      .r1     (r1),
      .r2     (r2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0;
      addr1w = '0; addr2w = '0; cnt1w = '0; cnt2w = '0;
      din1 = '0; din2 = '0; i1 = '0; i2 = '0;
      #2;
      chk("rst_out1", out1, 8'h00);
      chk("rst_r1",   r1,   8'h00);
      chk("rst_out2", out2, 8'h00);
      chk("rst_r2",   r2,   8'h00);
      step(); step();
      reset = 1'b1;

      // fill both channels
      wr_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         addr1w = 4'(k); din1 = 8'(8'h10 + k); i1 = 8'(2 * k);
         addr2w = 4'(k); din2 = 8'(8'hA0 + k); i2 = 8'(3 * k);
         step();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cnt1w = 4'(k); cnt2w = 4'(k);
         step();
         chk("fill_out1", out1, 8'(8'h10 + k));
         chk("fill_r1",   r1,   8'(2 * k));
         chk("fill_out2", out2, 8'(8'hA0 + k));
         chk("fill_r2",   r2,   8'(3 * k));
      end

      // write gating
      addr1w = 4'd5; din1 = 8'hFF; i1 = 8'hEE; cnt1w = 4'd0;
      step();
      cnt1w = 4'd5;
      step();
      chk("gate_out1", out1, 8'h15);
      chk("gate_r1",   r1,   8'h0A);

      // read-before-write on entry 7; channel 2 rewrites entry 0 with its own values
      addr2w = 4'd0; din2 = 8'hA0; i2 = 8'h00;
      wr_en = 1'b1; addr1w = 4'd7; din1 = 8'h99; i1 = 8'h55; cnt1w = 4'd7;
      step();
      chk("rbw_old_out1", out1, 8'h17);
      chk("rbw_old_r1",   r1,   8'h0E);
      wr_en = 1'b0;
      step();
      chk("rbw_new_out1", out1, 8'h99);
      chk("rbw_new_r1",   r1,   8'h55);

      // channel independence: ch1 traffic while ch2 reads entry 9
      wr_en = 1'b1; cnt2w = 4'd9;
      for (int k = 1; k < 4; k++) begin
         addr1w = 4'(k); din1 = 8'(8'h40 + k); i1 = 8'(8'h80 + k);
         step();
         chk("ind_out2", out2, 8'hA9);
         chk("ind_r2",   r2,   8'h1B);
      end
      wr_en = 1'b0;
      for (int k = 1; k < 4; k++) begin
         cnt1w = 4'(k); cnt2w = 4'(k);
         step();
         chk("ind_new_out1", out1, 8'(8'h40 + k));
         chk("ind_new_r1",   r1,   8'(8'h80 + k));
         chk("ind_keep_out2", out2, 8'(8'hA0 + k));
         chk("ind_keep_r2",   r2,   8'(3 * k));
      end

      // counter wrap
      cnt1w = 4'd14; step();
      chk("wrap14_out1", out1, 8'h1E);
      chk("wrap14_r1",   r1,   8'h1C);
      cnt1w = 4'd15; step();
      chk("wrap15_out1", out1, 8'h1F);
      chk("wrap15_r1",   r1,   8'h1E);
      cnt1w = 4'd0; step();
      chk("wrap0_out1",  out1, 8'h10);
      chk("wrap0_r1",    r1,   8'h00);

      // asynchronous reset mid-run, checked before any clock edge
      cnt1w = 4'd15; cnt2w = 4'd15; step();
      reset = 1'b0;
      #1;
      chk("arst_out1", out1, 8'h00);
      chk("arst_r1",   r1,   8'h00);
      chk("arst_out2", out2, 8'h00);
      chk("arst_r2",   r2,   8'h00);
      #1;
      reset = 1'b1; cnt1w = 4'd3; cnt2w = 4'd3; wr_en = 1'b0;
      step();
      chk("post_out1", out1, 8'h00);
      chk("post_r1",   r1,   8'h00);
      chk("post_out2", out2, 8'h00);
      chk("post_r2",   r2,   8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
